octa_decode_stage: RTL

Registered, parametrised instruction-decode stage for the Octa16 8-bit ISA. It buffers fetched instructions with their PC tags in a DEPTH-entry queue and decodes the queue head. Decoded fields go into an output register with valid/ready handshakes on both sides. It adds instruction-class flags, register-use flags, configurable immediate extension and flush, and sits between fetch and the register-read/execute stage.

---
 rtl/octa_pkg.sv | 87 ++++++++
 rtl/octa_inst_fifo.sv | 49 ++++
 rtl/octa_decode_stage.sv | 93 +++++++++
 3 files changed

// File: rtl/octa_pkg.sv
// Octa16 ISA definitions: opcodes, instruction-class bit positions and the
// width-independent field decoder used by the decode stage.
package octa_pkg;

  localparam logic [2:0] OP_LOGIC = 3'b000;
  localparam logic [2:0] OP_BLT   = 3'b001;
  localparam logic [2:0] OP_LD    = 3'b010;
  localparam logic [2:0] OP_ARITH = 3'b011;
  localparam logic [2:0] OP_SHIFT = 3'b100;
  localparam logic [2:0] OP_BEQ   = 3'b101;
  localparam logic [2:0] OP_ST    = 3'b110;
  localparam logic [2:0] OP_JMV   = 3'b111;

  localparam int CLS_W     = 7;
  localparam int CLS_ALU   = 0;
  localparam int CLS_SHIFT = 1;
  localparam int CLS_BR    = 2;
  localparam int CLS_LD    = 3;
  localparam int CLS_ST    = 4;
  localparam int CLS_JMP   = 5;
  localparam int CLS_MOV   = 6;

  // imm carries the raw 4-bit field; imm_ext3 marks a 3-bit field whose
  // extension (sign or zero) is chosen by the instantiating stage.
  typedef struct packed {
    logic [CLS_W-1:0] cls;
    logic [3:0]       fn;
    logic [1:0]       rs1;
    logic [1:0]       rs2;
    logic [3:0]       imm;
    logic             imm_ext3;
    logic             use_rs1;
    logic             use_rs2;
    logic             we;
  } dec_t;

  function automatic dec_t decode(input logic [7:0] i);
    dec_t d;
    d = '0;
    case (i[2:0])
      OP_LOGIC, OP_ARITH, OP_SHIFT: begin
        if (i[2:0] == OP_SHIFT) d.cls[CLS_SHIFT] = 1'b1;
        else                    d.cls[CLS_ALU]   = 1'b1;
        d.rs1     = {i[4], i[6]};
        d.rs2     = {i[5], i[7]};
        d.fn      = i[3:0];
        d.use_rs1 = 1'b1;
        d.use_rs2 = 1'b1;
        d.we      = 1'b1;
      end
      OP_BLT, OP_BEQ, OP_ST: begin
        if (i[2:0] == OP_ST) d.cls[CLS_ST] = 1'b1;
        else                 d.cls[CLS_BR] = 1'b1;
        d.rs1      = {1'b0, i[6]};
        d.rs2      = {1'b0, i[7]};
        d.fn       = {1'b0, i[2:0]};
        d.imm      = {1'b0, i[5:3]};
        d.imm_ext3 = 1'b1;
        d.use_rs1  = 1'b1;
        d.use_rs2  = 1'b1;
      end
      OP_LD: begin
        d.cls[CLS_LD] = 1'b1;
        d.rs1     = {1'b0, i[7]};
        d.fn      = {1'b0, i[2:0]};
        d.imm     = i[6:3];
        d.use_rs1 = 1'b1;
        d.we      = 1'b1;
      end
      default: begin
        d.fn = i[3:0];
        if (i[3]) begin
          d.cls[CLS_JMP] = 1'b1;
          d.imm          = i[7:4];
        end else begin
          d.cls[CLS_MOV] = 1'b1;
          d.rs1     = {i[4], i[6]};
          d.rs2     = {i[5], i[7]};
          d.use_rs2 = 1'b1;
          d.we      = 1'b1;
        end
      end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/octa_inst_fifo.sv
// Instruction/tag queue: synchronous FIFO with single-cycle flush.
module octa_inst_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          wr, rd;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign wr    = push && !full;
  assign rd    = pop && !empty;
  assign rdata = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + 1'b1;
      if (rd) rd_ptr <= rd_ptr + 1'b1;
      if (wr && !rd)      count <= count + 1'b1;
      else if (rd && !wr) count <= count - 1'b1;
    end
  end

  // Storage needs no reset: it is only read through a non-empty head.
  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/octa_decode_stage.sv
// Octa16 decode stage: queued fetch input, head decode into a registered
// valid/ready output with immediate extension and flush.
module octa_decode_stage
  import octa_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 8,
  parameter int IMM_W   = 8,
  parameter int BR_SEXT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_inst,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [TAG_W-1:0] out_tag,
  output logic [6:0]       out_cls,
  output logic [3:0]       out_fn,
  output logic [1:0]       out_rs1,
  output logic [1:0]       out_rs2,
  output logic [IMM_W-1:0] out_imm,
  output logic             out_use_rs1,
  output logic             out_use_rs2,
  output logic             out_we
);

  logic             full, empty, push, load;
  logic [7:0]       head_inst;
  logic [TAG_W-1:0] head_tag;
  logic [IMM_W-1:0] imm_ext;
  dec_t             dec;

  assign in_ready = !full && !rst;
  assign push     = in_valid && in_ready && !flush;
  assign load     = !empty && (!out_valid || out_ready) && !flush;

  octa_inst_fifo #(.DEPTH(DEPTH), .W(8 + TAG_W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (push),
    .wdata ({in_inst, in_tag}),
    .pop   (load),
    .rdata ({head_inst, head_tag}),
    .full  (full),
    .empty (empty)
  );

  assign dec = decode(head_inst);

  always_comb begin
    imm_ext = '0;
    if (dec.imm_ext3) begin
      imm_ext[2:0] = dec.imm[2:0];
      if (BR_SEXT != 0 && dec.imm[2]) imm_ext[IMM_W-1:3] = '1;
    end else begin
      imm_ext[3:0] = dec.imm;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      out_valid   <= 1'b0;
      out_tag     <= '0;
      out_cls     <= '0;
      out_fn      <= '0;
      out_rs1     <= '0;
      out_rs2     <= '0;
      out_imm     <= '0;
      out_use_rs1 <= 1'b0;
      out_use_rs2 <= 1'b0;
      out_we      <= 1'b0;
    end else if (load) begin
      out_valid   <= 1'b1;
      out_tag     <= head_tag;
      out_cls     <= dec.cls;
      out_fn      <= dec.fn;
      out_rs1     <= dec.rs1;
      out_rs2     <= dec.rs2;
      out_imm     <= imm_ext;
      out_use_rs1 <= dec.use_rs1;
      out_use_rs2 <= dec.use_rs2;
      out_we      <= dec.we;
    end else if (out_ready) begin
      out_valid   <= 1'b0;
    end
  end

endmodule
